// File: rtl/fifo_uart_drain_pkg.sv
// Shared types and constants for the FIFO-to-UART drain block.
package fifo_uart_drain_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned FRAME_BITS = DATA_W_DEF + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, wraps on its own, clears on state entry.
module uart_bit_timer
  import fifo_uart_drain_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || bit_end_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_end_c = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_drain.sv
// Drains an 8-bit synchronous FIFO one byte at a time and sends each byte as an 8N1 frame.
module fifo_uart_drain
  import fifo_uart_drain_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_re,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned     IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_e            state, state_d;
  logic [DATA_W-1:0] shift, shift_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic              fifo_re_d, tx_d, busy_d, frame_done_d;
  logic              bit_end_c, timer_clr_c;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (timer_clr_c),
    .bit_end_c (bit_end_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      idx        <= '0;
      fifo_re    <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      shift      <= shift_d;
      idx        <= idx_d;
      fifo_re    <= fifo_re_d;
      tx         <= tx_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

  // Outputs are derived from the next state so the registered copies line up with state.
  always_comb begin
    state_d      = state;
    shift_d      = shift;
    idx_d        = idx;
    timer_clr_c  = 1'b0;
    fifo_re_d    = 1'b0;
    tx_d         = 1'b1;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (en && !fifo_empty) begin
          state_d = READ;
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        shift_d = fifo_data;
        state_d = START;
      end
      START: begin
        if (bit_end_c) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          shift_d = shift >> 1;
          idx_d   = idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end_c) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    timer_clr_c  = (state_d != state);
    fifo_re_d    = (state_d == READ);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state == STOP) && (state_d == IDLE);
    if (state_d == START) begin
      tx_d = 1'b0;
    end else if (state_d == DATA) begin
      tx_d = shift_d[0];
    end
  end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Self-checking bench: FIFO read-side model plus frame-level UART reference.
module tb_fifo_uart_drain;
  import fifo_uart_drain_pkg::*;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_re;
  logic       tx;
  logic       busy;
  logic       frame_done;

  // Bench-side FIFO: the initial block pushes, the read strobe pops.
  logic [7:0] mem [0:255];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       underflow_seen = 1'b0;
  logic       overlap_seen = 1'b0;
  int         re_count = 0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  fifo_uart_drain #(
    .DATA_W       (8),
    .CLKS_PER_BIT (CPB),
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_re    (fifo_re),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always @(posedge clk) begin
    if (fifo_re === 1'b1) begin
      if (rd_ptr == wr_ptr) begin
        underflow_seen <= 1'b1;
      end else begin
        fifo_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (fifo_re === 1'b1) re_count <= re_count + 1;
    if (fifo_re === 1'b1 && frame_done === 1'b1) overlap_seen <= 1'b1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // Reference frame: start(0), data LSB first, stop(1); each bit held CPB cycles.
  task automatic check_frame(input logic [7:0] b, input int exp_wait, input int drop_at,
                             input string tag);
    logic [FRAME_BITS-1:0] frame;
    logic [7:0] rx;
    logic       found, bad;
    logic [3:0] obs;
    int         waits;
    frame = {1'b1, b, 1'b0};
    found = 1'b0;
    waits = 0;
    while (!found && waits < 2000) begin
      tick();
      waits++;
      if (tx === 1'b0) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL %s start: no start bit within %0d cycles, want one", tag, waits);
      return;
    end
    if (exp_wait >= 0) begin
      n_cmp++;
      if (waits != exp_wait) begin
        n_err++;
        $display("FAIL %s latency: got %0d cycles, want %0d", tag, waits, exp_wait);
      end
    end
    rx = 8'h00;
    for (int j = 0; j < int'(FRAME_BITS); j++) begin
      bad = 1'b0;
      obs = 4'b0000;
      for (int c = 0; c < CPB; c++) begin
        if (j * CPB + c == drop_at) en = 1'b0;
        if (!bad && (tx !== frame[j] || busy !== 1'b1 || frame_done !== 1'b0 ||
                     fifo_re !== 1'b0)) begin
          bad = 1'b1;
          obs = {tx, busy, frame_done, fifo_re};
        end
        if (c == CPB / 2 && j >= 1 && j <= 8) rx[j-1] = tx;
        tick();
      end
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("FAIL %s bit%0d: got {tx,busy,frame_done,fifo_re}=%b, want %b100",
                 tag, j, obs, frame[j]);
      end
    end
    n_cmp++;
    if (rx !== b) begin
      n_err++;
      $display("FAIL %s decode: got %h, want %h", tag, rx, b);
    end
    n_cmp++;
    if ({tx, busy, frame_done, fifo_re} !== 4'b1010) begin
      n_err++;
      $display("FAIL %s frame_done: got {tx,busy,frame_done,fifo_re}=%b, want 1010",
               tag, {tx, busy, frame_done, fifo_re});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    push(8'hA5);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({tx, fifo_re, busy, frame_done} !== 4'b1000) begin
        n_err++;
        $display("FAIL reset cycle%0d: got {tx,fifo_re,busy,frame_done}=%b, want 1000",
                 i, {tx, fifo_re, busy, frame_done});
      end
    end
    en  = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single_byte();
    int r0;
    r0 = re_count;
    en = 1'b1;
    check_frame(8'hA5, 3, -1, "single");
    n_cmp++;
    if (re_count - r0 != 1 || fifo_empty !== 1'b1) begin
      n_err++;
      $display("FAIL single reads: got %0d reads empty=%b, want 1 reads empty=1",
               re_count - r0, fifo_empty);
    end
  endtask

  task automatic test_three_bytes();
    int r0;
    r0 = re_count;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    check_frame(8'h00, 3, -1, "three0");
    check_frame(8'hFF, 3, -1, "three1");
    check_frame(8'h3C, 3, -1, "three2");
    n_cmp++;
    if (re_count - r0 != 3 || fifo_empty !== 1'b1 || underflow_seen !== 1'b0) begin
      n_err++;
      $display("FAIL three reads: got %0d reads empty=%b underflow=%b, want 3 1 0",
               re_count - r0, fifo_empty, underflow_seen);
    end
  endtask

  task automatic test_empty_idle();
    logic bad;
    int   r0;
    r0  = re_count;
    bad = 1'b0;
    en  = 1'b1;
    repeat (100) begin
      tick();
      if (fifo_re !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad || re_count != r0) begin
      n_err++;
      $display("FAIL empty_idle: got activity=%b reads=%0d, want activity=0 reads=0",
               bad, re_count - r0);
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    int   waits, r0;
    r0 = re_count;
    en = 1'b1;
    push(8'h5A);
    found = 1'b0;
    waits = 0;
    while (!found && waits < 100) begin
      tick();
      waits++;
      if (tx === 1'b0) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL reset_mid start: got no start bit in %0d cycles, want one", waits);
    end
    repeat (CPB * 4 + 1) tick();
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid bit3: got tx=%b busy=%b, want tx=1 busy=1", tx, busy);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({tx, busy, fifo_re, frame_done} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_mid after: got {tx,busy,fifo_re,frame_done}=%b, want 1000",
               {tx, busy, fifo_re, frame_done});
    end
    rst = 1'b0;
    n_cmp++;
    if (re_count - r0 != 1 || fifo_empty !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid drop: got %0d reads empty=%b, want 1 reads empty=1",
               re_count - r0, fifo_empty);
    end
    push(8'hC3);
    push(8'h81);
    check_frame(8'hC3, 3, -1, "post_reset0");
    check_frame(8'h81, 3, -1, "post_reset1");
  endtask

  task automatic test_en_drop();
    logic bad;
    int   r0;
    r0 = re_count;
    en = 1'b1;
    push(8'h96);
    push(8'h4B);
    check_frame(8'h96, 3, 20, "en_drop");
    bad = 1'b0;
    repeat (60) begin
      tick();
      if (fifo_re !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad || re_count - r0 != 1 || wr_ptr - rd_ptr != 1) begin
      n_err++;
      $display("FAIL en_drop hold: got activity=%b reads=%0d left=%0d, want 0 1 1",
               bad, re_count - r0, wr_ptr - rd_ptr);
    end
    en = 1'b1;
    check_frame(8'h4B, 3, -1, "en_resume");
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int         nb;
    en = 1'b1;
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(0, 7)) tick();
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        push(b);
      end
      while (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        check_frame(b, 3, -1, "random");
      end
    end
  endtask

  task automatic test_final_flags();
    n_cmp++;
    if (underflow_seen !== 1'b0 || overlap_seen !== 1'b0) begin
      n_err++;
      $display("FAIL final_flags: got underflow=%b re_with_done=%b, want 0 0",
               underflow_seen, overlap_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_three_bytes();
    test_empty_idle();
    test_reset_mid();
    test_en_drop();
    test_random();
    test_final_flags();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
